// File: rtl/log_fix_pkg.sv
// Shared definitions for the fixed-point log engines: base-mode encodings,
// Q15 base-conversion coefficients and the log2(1+f) table generator.
package log_fix_pkg;

    typedef enum logic [1:0] {
        LOG_MODE_LOG2  = 2'd0,
        LOG_MODE_LN    = 2'd1,
        LOG_MODE_LOG10 = 2'd2,
        LOG_MODE_DB    = 2'd3
    } log_mode_e;

    localparam int COEF_W    = 18;
    localparam int COEF_FRAC = 15;

    localparam logic signed [COEF_W-1:0] COEF_LOG2  = 18'sd32768;
    localparam logic signed [COEF_W-1:0] COEF_LN    = 18'sd22713;
    localparam logic signed [COEF_W-1:0] COEF_LOG10 = 18'sd9864;
    localparam logic signed [COEF_W-1:0] COEF_DB    = 18'sd98642;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic logic signed [COEF_W-1:0] mode_coef(input log_mode_e mode);
        logic signed [COEF_W-1:0] c;
        c = COEF_LOG2;
        case (mode)
            LOG_MODE_LOG2:  c = COEF_LOG2;
            LOG_MODE_LN:    c = COEF_LN;
            LOG_MODE_LOG10: c = COEF_LOG10;
            LOG_MODE_DB:    c = COEF_DB;
            default:        c = COEF_LOG2;
        endcase
        return c;
    endfunction

    // round(log2(1 + idx/2^addr_bits) * 2^out_frac), evaluated with integer
    // repeated squaring on a Q30 mantissa so no real arithmetic reaches synthesis.
    function automatic int log2_lut_entry(input int idx, input int addr_bits, input int out_frac);
        logic [63:0] x;
        logic [63:0] acc;
        x   = (64'(idx) + (64'd1 << addr_bits)) << (30 - addr_bits);
        acc = '0;
        for (int b = 0; b < 24; b++) begin
            x   = (x * x) >> 30;
            acc = acc << 1;
            if (x >= (64'd1 << 31)) begin
                acc = acc | 64'd1;
                x   = x >> 1;
            end
        end
        acc = (acc + (64'd1 << (23 - out_frac))) >> (24 - out_frac);
        return int'(acc);
    endfunction

endpackage

// File: rtl/log2_frac_lut.sv
// log2(1+f) for a normalised mantissa: table lookup plus linear interpolation,
// one registered stage, result rounded to FRAC_W fractional bits.
module log2_frac_lut
    import log_fix_pkg::*;
#(
    parameter int LUT_ADDR = 6,
    parameter int FRAC_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [LUT_ADDR+FRAC_W+1:0]   frac,
    output logic [FRAC_W:0]              lf
);

    localparam int T_W = FRAC_W + 2;
    localparam int E_W = T_W + 1;
    localparam int N   = 1 << LUT_ADDR;
    localparam int A_W = E_W + T_W + 1;
    localparam int SH  = 2 * T_W - FRAC_W;

    logic [E_W-1:0] table_rom [0:N];

    for (genvar i = 0; i <= N; i++) begin : g_rom
        assign table_rom[i] = E_W'(log2_lut_entry(i, LUT_ADDR, T_W));
    end

    logic [LUT_ADDR:0] idx;
    logic [LUT_ADDR:0] idx_next;
    logic [T_W-1:0]    t;
    logic [E_W-1:0]    y0;
    logic [E_W-1:0]    y1;
    logic [E_W-1:0]    dy;
    logic [A_W-1:0]    acc;
    logic [A_W-1:0]    acc_rnd;

    always_comb begin
        idx      = (LUT_ADDR+1)'(frac >> T_W);
        idx_next = idx + 1'b1;
        t        = T_W'(frac);
        y0       = table_rom[idx];
        y1       = table_rom[idx_next];
        // table is monotonic, so the slope is never negative
        dy       = y1 - y0;
        acc      = (A_W'(y0) << T_W) + A_W'(dy) * A_W'(t);
        acc_rnd  = acc + A_W'(64'd1 << (SH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lf <= '0;
        end else if (en) begin
            lf <= (FRAC_W+1)'(acc_rnd >> SH);
        end
    end

endmodule

// File: rtl/log_fix_multi.sv
// Six-stage pipelined fixed-point logarithm (log2 / ln / log10 / dB) of an
// unsigned magnitude, referenced to 2^OFFSET, with zero and saturation flags.
module log_fix_multi
    import log_fix_pkg::*;
#(
    parameter int IN_W     = 64,
    parameter int FRAC_W   = 8,
    parameter int LUT_ADDR = 6,
    parameter int OFFSET   = 12,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 8,
    parameter int TAG_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    input  logic [IN_W-1:0]         i_data,
    input  logic [1:0]              i_mode,
    input  logic [TAG_W-1:0]        i_tag,
    output logic                    o_valid,
    output logic signed [OUT_W-1:0] o_data,
    output logic [TAG_W-1:0]        o_tag,
    output logic                    o_zero,
    output logic                    o_sat
);

    localparam int K_W    = clog2(IN_W);
    localparam int FIDX_W = LUT_ADDR + FRAC_W + 2;
    localparam int X_W    = IN_W - 1 + FIDX_W;
    localparam int D_W    = K_W + FRAC_W + 2;
    localparam int P_W    = D_W + COEF_W;
    localparam int S      = COEF_FRAC + FRAC_W - OUT_FRAC;

    localparam logic signed [D_W-1:0]   OFFSET_Q = D_W'(OFFSET << FRAC_W);
    localparam logic signed [OUT_W-1:0] OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [P_W:0]     SAT_MAX  = (P_W+1)'(OUT_MAX);
    localparam logic signed [P_W:0]     SAT_MIN  = (P_W+1)'(OUT_MIN);
    localparam logic signed [P_W:0]     RND      = (P_W+1)'(64'd1 << (S - 1));

    if (OUT_FRAC > FRAC_W) begin : g_bad_out_frac
        $error("log_fix_multi: OUT_FRAC must not exceed FRAC_W");
    end
    if (IN_W < 8) begin : g_bad_in_w
        $error("log_fix_multi: IN_W must be at least 8");
    end

    // stage 1: leading-one detect
    logic [K_W-1:0] lod_k;
    always_comb begin
        lod_k = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (i_data[i]) lod_k = K_W'(i);
        end
    end

    logic              s1_valid, s1_zero;
    logic [IN_W-1:0]   s1_data;
    logic [K_W-1:0]    s1_k;
    log_mode_e         s1_mode;
    logic [TAG_W-1:0]  s1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
            s1_data  <= '0;
            s1_k     <= '0;
            s1_mode  <= LOG_MODE_LOG2;
            s1_tag   <= '0;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_zero <= (i_data == '0);
                s1_data <= i_data;
                s1_k    <= lod_k;
                s1_mode <= log_mode_e'(i_mode);
                s1_tag  <= i_tag;
            end
        end
    end

    // stage 2: normalise; the leading one falls off the top of norm_ext
    logic [K_W-1:0]  norm_sh;
    logic [IN_W-1:0] norm;
    logic [X_W-1:0]  norm_ext;
    always_comb begin
        norm_sh  = K_W'(IN_W - 1) - s1_k;
        norm     = s1_data << norm_sh;
        norm_ext = X_W'(norm) << FIDX_W;
    end

    logic              s2_valid, s2_zero;
    logic [FIDX_W-1:0] s2_frac;
    logic [K_W-1:0]    s2_k;
    log_mode_e         s2_mode;
    logic [TAG_W-1:0]  s2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_zero  <= 1'b0;
            s2_frac  <= '0;
            s2_k     <= '0;
            s2_mode  <= LOG_MODE_LOG2;
            s2_tag   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_zero <= s1_zero;
                s2_frac <= FIDX_W'(norm_ext >> (X_W - FIDX_W));
                s2_k    <= s1_k;
                s2_mode <= s1_mode;
                s2_tag  <= s1_tag;
            end
        end
    end

    // stage 3: fractional log2 from the table
    logic [FRAC_W:0] s3_lf;

    log2_frac_lut #(
        .LUT_ADDR (LUT_ADDR),
        .FRAC_W   (FRAC_W)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (s2_valid),
        .frac  (s2_frac),
        .lf    (s3_lf)
    );

    logic             s3_valid, s3_zero;
    logic [K_W-1:0]   s3_k;
    log_mode_e        s3_mode;
    logic [TAG_W-1:0] s3_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_zero  <= 1'b0;
            s3_k     <= '0;
            s3_mode  <= LOG_MODE_LOG2;
            s3_tag   <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_zero <= s2_zero;
                s3_k    <= s2_k;
                s3_mode <= s2_mode;
                s3_tag  <= s2_tag;
            end
        end
    end

    // stage 4: assemble offset-referenced log2, pick the base coefficient
    logic                     s4_valid, s4_zero;
    logic signed [D_W-1:0]    s4_d;
    logic signed [COEF_W-1:0] s4_coef;
    logic [TAG_W-1:0]         s4_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s4_valid <= 1'b0;
            s4_zero  <= 1'b0;
            s4_d     <= '0;
            s4_coef  <= '0;
            s4_tag   <= '0;
        end else begin
            s4_valid <= s3_valid;
            if (s3_valid) begin
                s4_zero <= s3_zero;
                s4_d    <= $signed(D_W'({s3_k, FRAC_W'(0)})) + $signed(D_W'(s3_lf)) - OFFSET_Q;
                s4_coef <= mode_coef(s3_mode);
                s4_tag  <= s3_tag;
            end
        end
    end

    // stage 5: base conversion
    logic                  s5_valid, s5_zero;
    logic signed [P_W-1:0] s5_p;
    logic [TAG_W-1:0]      s5_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s5_valid <= 1'b0;
            s5_zero  <= 1'b0;
            s5_p     <= '0;
            s5_tag   <= '0;
        end else begin
            s5_valid <= s4_valid;
            if (s4_valid) begin
                s5_zero <= s4_zero;
                s5_p    <= P_W'(s4_d) * P_W'(s4_coef);
                s5_tag  <= s4_tag;
            end
        end
    end

    // stage 6: round half up, saturate; zero input pins the negative rail
    logic signed [P_W:0] p_rnd;
    logic signed [P_W:0] r_full;
    always_comb begin
        p_rnd  = (P_W+1)'(s5_p) + RND;
        r_full = p_rnd >>> S;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_tag   <= '0;
            o_zero  <= 1'b0;
            o_sat   <= 1'b0;
        end else begin
            o_valid <= s5_valid;
            if (s5_valid) begin
                o_tag  <= s5_tag;
                o_zero <= s5_zero;
                if (s5_zero) begin
                    o_data <= OUT_MIN;
                    o_sat  <= 1'b1;
                end else if (r_full > SAT_MAX) begin
                    o_data <= OUT_MAX;
                    o_sat  <= 1'b1;
                end else if (r_full < SAT_MIN) begin
                    o_data <= OUT_MIN;
                    o_sat  <= 1'b1;
                end else begin
                    o_data <= OUT_W'(r_full);
                    o_sat  <= 1'b0;
                end
            end
        end
    end

endmodule
